// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the data_mem port.
// Takes one execute-stage load/store request at a time and computes the effective
// address as base + sign-extended 12-bit offset. It screens the request for
// misalignment, range and illegal funct3. It then drives a single data_mem access
// and returns the result to writeback over a valid/ready handshake.
// Width selection and sign/zero extension of load data are done inside data_mem.
module load_store_unit #(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_base,
    input  logic [11:0]       req_offset,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [4:0]        rsp_rd,
    output logic              rsp_fault,
    output logic [31:0]       rsp_fault_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_val,
    input  logic [31:0]       mem_read_val
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    // WAIT counts down from MEM_LAT-1; unused when MEM_LAT is 0.
    localparam logic [1:0] WAIT_INIT = (MEM_LAT > 0) ? 2'(MEM_LAT - 1) : 2'd0;

    state_e            state_q;
    logic              is_store_q;
    logic [1:0]        wait_cnt_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic [4:0]        rsp_rd_q;
    logic              rsp_fault_q;
    logic [31:0]       rsp_fault_addr_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [2:0]        mem_funct3_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_write_val_q;

    logic [31:0]       eff_addr_s;
    logic              misalign_s;
    logic              range_bad_s;
    logic              fault_s;
    logic              accept_s;

    // Encodings outside the RV32I load/store subsets are rejected up front.
    function automatic logic funct3_illegal(input logic is_store, input logic [2:0] f3);
        logic bad;
        if (is_store) begin
            bad = (f3 > 3'd2);
        end else begin
            bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        end
        return bad;
    endfunction

    // Effective address and fault screening of the request on the input port.
    always_comb begin
        eff_addr_s  = req_base + {{20{req_offset[11]}}, req_offset};
        range_bad_s = ((eff_addr_s >> ADDR_W) != 32'd0);
        case (req_funct3[1:0])
            2'b01:   misalign_s = eff_addr_s[0];
            2'b10:   misalign_s = (eff_addr_s[1:0] != 2'b00);
            default: misalign_s = 1'b0;
        endcase
        fault_s  = funct3_illegal(req_is_store, req_funct3) || misalign_s || range_bad_s;
        accept_s = req_valid && req_ready;
    end

    // Idle is the only accepting state; held low while reset is asserted.
    assign req_ready = (state_q == S_IDLE) && rst_n;

    // Access sequencer: request capture, memory strobe, latency wait, response hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            is_store_q       <= 1'b0;
            wait_cnt_q       <= 2'd0;
            rsp_valid_q      <= 1'b0;
            rsp_rdata_q      <= 32'd0;
            rsp_rd_q         <= 5'd0;
            rsp_fault_q      <= 1'b0;
            rsp_fault_addr_q <= 32'd0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_funct3_q     <= 3'd0;
            mem_addr_q       <= '0;
            mem_write_val_q  <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        is_store_q <= req_is_store;
                        rsp_rd_q   <= req_rd;
                        if (fault_s) begin
                            // A faulting request never touches data_mem.
                            rsp_valid_q      <= 1'b1;
                            rsp_fault_q      <= 1'b1;
                            rsp_fault_addr_q <= eff_addr_s;
                            rsp_rdata_q      <= 32'd0;
                            state_q          <= S_RESP;
                        end else begin
                            mem_read_q      <= !req_is_store;
                            mem_write_q     <= req_is_store;
                            mem_addr_q      <= eff_addr_s[ADDR_W-1:0];
                            mem_funct3_q    <= req_funct3;
                            mem_write_val_q <= req_is_store ? req_wdata : 32'd0;
                            state_q         <= S_ISSUE;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    if (is_store_q || (MEM_LAT == 0)) begin
                        rsp_rdata_q     <= is_store_q ? 32'd0 : mem_read_val;
                        rsp_valid_q     <= 1'b1;
                        rsp_fault_q     <= 1'b0;
                        rsp_fault_addr_q <= 32'd0;
                        mem_addr_q      <= '0;
                        mem_funct3_q    <= 3'd0;
                        mem_write_val_q <= 32'd0;
                        state_q         <= S_RESP;
                    end else begin
                        wait_cnt_q <= WAIT_INIT;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_q == 2'd0) begin
                        rsp_rdata_q      <= mem_read_val;
                        rsp_valid_q      <= 1'b1;
                        rsp_fault_q      <= 1'b0;
                        rsp_fault_addr_q <= 32'd0;
                        mem_addr_q       <= '0;
                        mem_funct3_q     <= 3'd0;
                        mem_write_val_q  <= 32'd0;
                        state_q          <= S_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 2'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q      <= 1'b0;
                        rsp_rdata_q      <= 32'd0;
                        rsp_rd_q         <= 5'd0;
                        rsp_fault_q      <= 1'b0;
                        rsp_fault_addr_q <= 32'd0;
                        state_q          <= S_IDLE;
                    end else begin
                        state_q <= S_RESP;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_rd         = rsp_rd_q;
    assign rsp_fault      = rsp_fault_q;
    assign rsp_fault_addr = rsp_fault_addr_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_funct3     = mem_funct3_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_val  = mem_write_val_q;

endmodule
